mdu_iter: RTL and testbench

MDU_ITER -- requirements
Module: mdu_iter

---
 rtl/mdu_iter.sv | 177 +++++++++++++++++
 tb/tb_mdu_iter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: one radix-2 step per cycle over WIDTH cycles,
// with signed/unsigned multiply, divide, divide-by-zero and annul handling.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             annul,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             dz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } stateT;

    localparam int              CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH);

    stateT             state;
    stateT             stateNext;

    logic [1:0]        opReg;
    logic [WIDTH-1:0]  aRaw;
    logic [WIDTH-1:0]  bRaw;
    logic [WIDTH-1:0]  opnd;
    logic [WIDTH-1:0]  accHi;
    logic [WIDTH-1:0]  accLo;
    logic [CntW-1:0]   cnt;
    logic              negRes;
    logic              negRem;

    logic [WIDTH-1:0]  resHi;
    logic [WIDTH-1:0]  resLo;
    logic              resDz;

    logic              isDiv;
    logic              isSigned;
    logic [WIDTH-1:0]  magA;
    logic [WIDTH-1:0]  magB;

    logic [WIDTH:0]    mulSum;
    logic [WIDTH:0]    divShift;
    logic              divFits;
    logic [WIDTH-1:0]  divSub;
    logic [WIDTH-1:0]  stepHi;
    logic [WIDTH-1:0]  stepLo;

    logic [2*WIDTH-1:0] prodMag;
    logic [WIDTH-1:0]  fixHi;
    logic [WIDTH-1:0]  fixLo;
    logic              fixDz;

    assign isDiv    = opReg[1];
    assign isSigned = ~opReg[0];
    assign magA     = (isSigned && aRaw[WIDTH-1]) ? -aRaw : aRaw;
    assign magB     = (isSigned && bRaw[WIDTH-1]) ? -bRaw : bRaw;

    always_comb begin
        // NOTE: defaults come first so every path assigns stateNext and no latch is inferred.
        stateNext = state;
        unique case (state)
            IDLE, DONE: stateNext = (start && !annul) ? PREP : IDLE;
            PREP:       stateNext = annul ? IDLE : CALC;
            CALC: begin
                if (annul) begin
                    stateNext = IDLE;
                end else if (cnt == LastCnt) begin
                    stateNext = DONE;
                end
            end
            default:    stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Multiply adds at the top and shifts right; divide shifts left and restores on underflow.
    assign mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opnd} : {(WIDTH + 1){1'b0}});
    assign divShift = {accHi, accLo[WIDTH-1]};
    assign divFits  = divShift >= {1'b0, opnd};
    assign divSub   = divShift[WIDTH-1:0] - opnd;

    always_comb begin
        if (isDiv) begin
            stepHi = divFits ? divSub : divShift[WIDTH-1:0];
            stepLo = {accLo[WIDTH-2:0], divFits};
        end else begin
            stepHi = mulSum[WIDTH:1];
            stepLo = {mulSum[0], accLo[WIDTH-1:1]};
        end
    end

    assign prodMag = {accHi, accLo};

    always_comb begin
        fixHi = accHi;
        fixLo = accLo;
        fixDz = 1'b0;
        if (!isDiv) begin
            {fixHi, fixLo} = negRes ? -prodMag : prodMag;
        end else if (bRaw == '0) begin
            fixHi = aRaw;
            fixLo = '1;
            fixDz = 1'b1;
        end else begin
            // The most-negative / -1 case wraps back to the most-negative value here.
            fixLo = negRes ? -accLo : accLo;
            fixHi = negRem ? -accHi : accHi;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opReg  <= '0;
            aRaw   <= '0;
            bRaw   <= '0;
            opnd   <= '0;
            accHi  <= '0;
            accLo  <= '0;
            cnt    <= '0;
            negRes <= 1'b0;
            negRem <= 1'b0;
            resHi  <= '0;
            resLo  <= '0;
            resDz  <= 1'b0;
        end else begin
            if ((state == IDLE || state == DONE) && stateNext == PREP) begin
                opReg <= op;
                aRaw  <= a;
                bRaw  <= b;
            end
            if (state == PREP) begin
                opnd   <= isDiv ? magB : magA;
                accLo  <= isDiv ? magA : magB;
                accHi  <= '0;
                cnt    <= '0;
                negRes <= isSigned & (aRaw[WIDTH-1] ^ bRaw[WIDTH-1]);
                negRem <= isSigned & aRaw[WIDTH-1];
            end
            if (state == CALC && cnt != LastCnt) begin
                accHi <= stepHi;
                accLo <= stepLo;
                cnt   <= cnt + CntW'(1);
            end
            if (state == CALC && stateNext == DONE) begin
                resHi <= fixHi;
                resLo <= fixLo;
                resDz <= fixDz;
            end
        end
    end

    assign busy      = (state == PREP) || (state == CALC);
    assign ready     = (state == DONE);
    assign result_hi = resHi;
    assign result_lo = resLo;
    assign dz        = resDz;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (WIDTH=32): directed vectors, randomized ops
// against an arithmetic reference, annul, reset abort and back-to-back timing.
module tb_mdu_iter;

    localparam int W = 32;
    localparam int Lat = W + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          annul = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy;
    logic          ready;
    logic [W-1:0]  result_hi;
    logic [W-1:0]  result_lo;
    logic          dz;

    int            nChecks = 0;
    int            nFails = 0;
    int            cyc = 0;
    logic [W-1:0]  prevHi = '0;
    logic [W-1:0]  prevLo = '0;
    logic          prevDz = 1'b0;

    mdu_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .annul(annul),
        .busy(busy), .ready(ready), .result_hi(result_hi), .result_lo(result_lo), .dz(dz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero.
    function automatic void refModel(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] h, output logic [31:0] l, output logic z);
        longint      sx;
        longint      sy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        z  = 1'b0;
        p  = '0;
        case (o)
            2'b00: p = 64'(sx * sy);
            2'b01: p = {32'd0, x} * {32'd0, y};
            default: begin
                if (y == 32'd0) begin
                    p = {x, 32'hFFFF_FFFF};
                    z = 1'b1;
                end else if (o == 2'b10) begin
                    p = {32'(sx % sy), 32'(sx / sy)};
                end else begin
                    p = {x % y, x / y};
                end
            end
        endcase
        h = p[63:32];
        l = p[31:0];
    endfunction

    // Issues one operation from the current phase and waits for ready (edge index in lat, -1 on timeout).
    task automatic doOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int glitchEdge, output int lat, output logic busy0, output int readyCyc);
        op = o; a = x; b = y; start = 1'b1;
        lat = -1; busy0 = 1'b0; readyCyc = -1;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (n == 0) begin
                start = 1'b0;
                busy0 = busy;
            end
            if (glitchEdge >= 0 && n == glitchEdge) begin
                start = 1'b1; op = ~o; a = ~x; b = y + 32'd1;
            end
            if (glitchEdge >= 0 && n == glitchEdge + 2) start = 1'b0;
            if (ready) begin
                lat = n;
                readyCyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int   lat;
        int   rc;
        logic b0;
        @(posedge clk); #1;
        nChecks += 5;
        if (busy !== 1'b0) begin nFails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (ready !== 1'b0) begin nFails++; $display("FAIL reset_ready: got %b expected 0", ready); end
        if (dz !== 1'b0) begin nFails++; $display("FAIL reset_dz: got %b expected 0", dz); end
        if (result_hi !== '0) begin nFails++; $display("FAIL reset_hi: got %h expected 0", result_hi); end
        if (result_lo !== '0) begin nFails++; $display("FAIL reset_lo: got %h expected 0", result_lo); end
        rst = 1'b1;
        doOp(2'b01, 32'd3, 32'd5, -1, lat, b0, rc);
        nChecks += 4;
        if (b0 !== 1'b1) begin nFails++; $display("FAIL first_start_busy: got %b expected 1", b0); end
        if (lat != Lat) begin nFails++; $display("FAIL first_start_latency: got %0d expected %0d", lat, Lat); end
        if (result_lo !== 32'd15) begin nFails++; $display("FAIL first_start_lo: got %h expected 0000000f", result_lo); end
        if (result_hi !== 32'd0) begin nFails++; $display("FAIL first_start_hi: got %h expected 00000000", result_hi); end
        prevHi = 32'd0; prevLo = 32'd15; prevDz = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] h;
        logic [31:0] l;
        logic        z;
    } vecT;

    task automatic test_directed();
        vecT  v[6];
        int   lat;
        int   rc;
        logic b0;
        v[0] = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
        v[1] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
        v[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        v[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        v[4] = '{2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1};
        v[5] = '{2'b01, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 1'b0};
        for (int i = 0; i < 6; i++) begin
            doOp(v[i].o, v[i].x, v[i].y, -1, lat, b0, rc);
            nChecks += 4;
            if (lat != Lat) begin nFails++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, Lat); end
            if (result_hi !== v[i].h) begin nFails++; $display("FAIL dir%0d_hi: got %h expected %h", i, result_hi, v[i].h); end
            if (result_lo !== v[i].l) begin nFails++; $display("FAIL dir%0d_lo: got %h expected %h", i, result_lo, v[i].l); end
            if (dz !== v[i].z) begin nFails++; $display("FAIL dir%0d_dz: got %b expected %b", i, dz, v[i].z); end
            @(posedge clk); #1;
            nChecks += 3;
            if (ready !== 1'b0) begin nFails++; $display("FAIL dir%0d_ready_pulse: got %b expected 0", i, ready); end
            if (result_hi !== v[i].h) begin nFails++; $display("FAIL dir%0d_hold_hi: got %h expected %h", i, result_hi, v[i].h); end
            if (result_lo !== v[i].l) begin nFails++; $display("FAIL dir%0d_hold_lo: got %h expected %h", i, result_lo, v[i].l); end
            prevHi = v[i].h; prevLo = v[i].l; prevDz = v[i].z;
        end
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] eh;
        logic [31:0] el;
        logic        ez;
        int          lat;
        int          rc;
        logic        b0;
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            x = pickOperand();
            y = pickOperand();
            refModel(o, x, y, eh, el, ez);
            doOp(o, x, y, -1, lat, b0, rc);
            nChecks += 4;
            if (lat != Lat) begin nFails++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, Lat); end
            if (result_hi !== eh) begin nFails++; $display("FAIL rnd%0d_hi op=%b a=%h b=%h: got %h expected %h", i, o, x, y, result_hi, eh); end
            if (result_lo !== el) begin nFails++; $display("FAIL rnd%0d_lo op=%b a=%h b=%h: got %h expected %h", i, o, x, y, result_lo, el); end
            if (dz !== ez) begin nFails++; $display("FAIL rnd%0d_dz op=%b a=%h b=%h: got %b expected %b", i, o, x, y, dz, ez); end
            prevHi = eh; prevLo = el; prevDz = ez;
        end
    endtask

    task automatic test_start_busy();
        logic [31:0] eh;
        logic [31:0] el;
        logic        ez;
        int          lat;
        int          rc;
        logic        b0;
        refModel(2'b00, 32'h1234_5678, 32'hFEDC_BA98, eh, el, ez);
        doOp(2'b00, 32'h1234_5678, 32'hFEDC_BA98, 5, lat, b0, rc);
        nChecks += 3;
        if (lat != Lat) begin nFails++; $display("FAIL busy_start_latency: got %0d expected %0d", lat, Lat); end
        if (result_hi !== eh) begin nFails++; $display("FAIL busy_start_hi: got %h expected %h", result_hi, eh); end
        if (result_lo !== el) begin nFails++; $display("FAIL busy_start_lo: got %h expected %h", result_lo, el); end
        prevHi = eh; prevLo = el; prevDz = ez;
    endtask

    task automatic test_annul();
        logic readySeen;
        int   lat;
        int   rc;
        logic b0;
        readySeen = 1'b0;
        op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
        for (int n = 0; n <= 11; n++) begin
            @(posedge clk); #1;
            if (n == 0) start = 1'b0;
            if (n == 10) annul = 1'b1;
            if (n == 11) annul = 1'b0;
            if (ready) readySeen = 1'b1;
        end
        nChecks += 5;
        if (busy !== 1'b0) begin nFails++; $display("FAIL annul_busy: got %b expected 0", busy); end
        if (readySeen !== 1'b0) begin nFails++; $display("FAIL annul_no_ready: got %b expected 0", readySeen); end
        if (result_hi !== prevHi) begin nFails++; $display("FAIL annul_hold_hi: got %h expected %h", result_hi, prevHi); end
        if (result_lo !== prevLo) begin nFails++; $display("FAIL annul_hold_lo: got %h expected %h", result_lo, prevLo); end
        if (dz !== prevDz) begin nFails++; $display("FAIL annul_hold_dz: got %b expected %b", dz, prevDz); end
        doOp(2'b11, 32'd100, 32'd7, -1, lat, b0, rc);
        nChecks += 3;
        if (lat != Lat) begin nFails++; $display("FAIL after_annul_latency: got %0d expected %0d", lat, Lat); end
        if (result_lo !== 32'h0000_000E) begin nFails++; $display("FAIL after_annul_lo: got %h expected 0000000e", result_lo); end
        if (result_hi !== 32'h0000_0002) begin nFails++; $display("FAIL after_annul_hi: got %h expected 00000002", result_hi); end
        prevHi = 32'd2; prevLo = 32'd14; prevDz = 1'b0;
        // Start with annul in DONE: annul wins, block drops to IDLE.
        start = 1'b1; annul = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0; annul = 1'b0;
        nChecks += 3;
        if (busy !== 1'b0) begin nFails++; $display("FAIL annul_start_busy: got %b expected 0", busy); end
        if (ready !== 1'b0) begin nFails++; $display("FAIL annul_start_ready: got %b expected 0", ready); end
        if (result_lo !== prevLo) begin nFails++; $display("FAIL annul_start_lo: got %h expected %h", result_lo, prevLo); end
    endtask

    task automatic test_rst_mid();
        logic readySeen;
        readySeen = 1'b0;
        op = 2'b00; a = 32'h0001_0003; b = 32'hFFFF_0007; start = 1'b1;
        for (int n = 0; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 0) start = 1'b0;
            if (ready) readySeen = 1'b1;
        end
        rst = 1'b0;
        #1;
        nChecks += 5;
        if (busy !== 1'b0) begin nFails++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        if (ready !== 1'b0) begin nFails++; $display("FAIL rst_mid_ready: got %b expected 0", ready); end
        if (dz !== 1'b0) begin nFails++; $display("FAIL rst_mid_dz: got %b expected 0", dz); end
        if (result_hi !== '0) begin nFails++; $display("FAIL rst_mid_hi: got %h expected 0", result_hi); end
        if (result_lo !== '0) begin nFails++; $display("FAIL rst_mid_lo: got %h expected 0", result_lo); end
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            if (ready) readySeen = 1'b1;
        end
        rst = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (ready) readySeen = 1'b1;
        end
        nChecks += 1;
        if (readySeen !== 1'b0) begin nFails++; $display("FAIL rst_mid_no_ready: got %b expected 0", readySeen); end
        prevHi = '0; prevLo = '0; prevDz = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] eh;
        logic [31:0] el;
        logic        ez;
        int          lat;
        int          rc1;
        int          rc2;
        logic        b0;
        refModel(2'b10, 32'hFFFF_FF9C, 32'd7, eh, el, ez);
        doOp(2'b10, 32'hFFFF_FF9C, 32'd7, -1, lat, b0, rc1);
        nChecks += 3;
        if (lat != Lat) begin nFails++; $display("FAIL b2b_first_latency: got %0d expected %0d", lat, Lat); end
        if (result_lo !== el) begin nFails++; $display("FAIL b2b_first_lo: got %h expected %h", result_lo, el); end
        if (result_hi !== eh) begin nFails++; $display("FAIL b2b_first_hi: got %h expected %h", result_hi, eh); end
        refModel(2'b01, 32'hDEAD_BEEF, 32'h0000_0010, eh, el, ez);
        doOp(2'b01, 32'hDEAD_BEEF, 32'h0000_0010, -1, lat, b0, rc2);
        nChecks += 3;
        if (rc2 - rc1 != W + 3) begin nFails++; $display("FAIL b2b_spacing: got %0d expected %0d", rc2 - rc1, W + 3); end
        if (result_lo !== el) begin nFails++; $display("FAIL b2b_second_lo: got %h expected %h", result_lo, el); end
        if (result_hi !== eh) begin nFails++; $display("FAIL b2b_second_hi: got %h expected %h", result_hi, eh); end
        prevHi = eh; prevLo = el; prevDz = ez;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_busy();
        test_annul();
        test_rst_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
